// File: rtl/rr_operand_stage_pkg.sv
// Shared register-read definitions: default lane geometry and the packet
// shapes exchanged between issue, register read and execute.
// Optional feature macro used by this slice: RR_BYPASS_EN.
package rr_operand_stage_pkg;

    localparam int RR_BYP_LANES = 4;
    localparam int RR_PHY_LOG   = 7;
    localparam int RR_DATA_W    = 64;
    localparam int RR_PAY_W     = 96;

    // Issued instruction as it sits in the read slot.
    typedef struct packed {
        logic                  valid;
        logic [RR_PHY_LOG-1:0] src1;
        logic [RR_PHY_LOG-1:0] src2;
        logic [RR_PAY_W-1:0]   payload;
    } rrIssuePkt;

    // Resolved operand packet handed to execute.
    typedef struct packed {
        logic                 valid;
        logic [RR_DATA_W-1:0] src1Data;
        logic [RR_DATA_W-1:0] src2Data;
        logic [RR_PAY_W-1:0]  payload;
    } rrExePkt;

    // One writeback bypass lane.
    typedef struct packed {
        logic                  valid;
        logic [RR_PHY_LOG-1:0] tag;
        logic [RR_DATA_W-1:0]  data;
    } bypassPkt;

endpackage

// File: rtl/rr_bypass_mux.sv
// Resolves one source operand: PRF read data, overridden by the lowest-index
// writeback lane whose tag matches. With RR_BYPASS_EN undefined the bypass
// inputs are ignored and the PRF data passes straight through.
module rr_bypass_mux
    import rr_operand_stage_pkg::*;
#(
    parameter int BYP_LANES = RR_BYP_LANES,
    parameter int PHY_LOG   = RR_PHY_LOG,
    parameter int DATA_W    = RR_DATA_W
) (
    input  logic [PHY_LOG-1:0]           tag_i,
    input  logic [DATA_W-1:0]            prf_data_i,
    input  logic [BYP_LANES-1:0]         byp_valid_i,
    input  logic [BYP_LANES*PHY_LOG-1:0] byp_tag_i,
    input  logic [BYP_LANES*DATA_W-1:0]  byp_data_i,
    output logic [DATA_W-1:0]            data_o
);

`ifdef RR_BYPASS_EN
    // Scan from the top lane down so the lowest matching lane is applied last.
    always_comb begin
        data_o = prf_data_i;
        for (int l = BYP_LANES - 1; l >= 0; l--) begin
            if (byp_valid_i[l] && (byp_tag_i[l*PHY_LOG +: PHY_LOG] == tag_i)) begin
                data_o = byp_data_i[l*DATA_W +: DATA_W];
            end
        end
    end
`else
    logic unused_byp;
    assign unused_byp = ^{tag_i, byp_valid_i, byp_tag_i, byp_data_i};
    assign data_o     = prf_data_i;
`endif

endmodule

// File: rtl/rr_operand_stage.sv
// Register-read stage for one issue lane: slot A holds the issued tags while
// the PRF is read, slot B holds resolved operands for execute.
// Optional feature macro: RR_BYPASS_EN (writeback bypass compare/mux).
module rr_operand_stage
    import rr_operand_stage_pkg::*;
#(
    parameter int BYP_LANES = RR_BYP_LANES,
    parameter int PHY_LOG   = RR_PHY_LOG,
    parameter int DATA_W    = RR_DATA_W,
    parameter int PAY_W     = RR_PAY_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issValid_i,
    input  logic [PHY_LOG-1:0]             issSrc1_i,
    input  logic [PHY_LOG-1:0]             issSrc2_i,
    input  logic [PAY_W-1:0]               issPayload_i,
    output logic                           rrReady_o,
    output logic [PHY_LOG-1:0]             phySrc1_o,
    output logic [PHY_LOG-1:0]             phySrc2_o,
    input  logic [DATA_W-1:0]              prfData1_i,
    input  logic [DATA_W-1:0]              prfData2_i,
    input  logic [BYP_LANES-1:0]           bypValid_i,
    input  logic [BYP_LANES*PHY_LOG-1:0]   bypTag_i,
    input  logic [BYP_LANES*DATA_W-1:0]    bypData_i,
    output logic                           exeValid_o,
    output logic [DATA_W-1:0]              exeSrc1_o,
    output logic [DATA_W-1:0]              exeSrc2_o,
    output logic [PAY_W-1:0]               exePayload_o,
    input  logic                           exeReady_i,
    input  logic                           flush_i
);

    logic               a_valid_q, a_valid_d;
    logic [PHY_LOG-1:0] a_src1_q, a_src1_d;
    logic [PHY_LOG-1:0] a_src2_q, a_src2_d;
    logic [PAY_W-1:0]   a_pay_q, a_pay_d;

    logic               b_valid_q, b_valid_d;
    logic [DATA_W-1:0]  b_src1_q, b_src1_d;
    logic [DATA_W-1:0]  b_src2_q, b_src2_d;
    logic [PAY_W-1:0]   b_pay_q, b_pay_d;

    logic               adv_a, adv_b;
    logic [DATA_W-1:0]  res1, res2;

    rr_bypass_mux #(
        .BYP_LANES (BYP_LANES),
        .PHY_LOG   (PHY_LOG),
        .DATA_W    (DATA_W)
    ) u_byp1 (
        .tag_i       (a_src1_q),
        .prf_data_i  (prfData1_i),
        .byp_valid_i (bypValid_i),
        .byp_tag_i   (bypTag_i),
        .byp_data_i  (bypData_i),
        .data_o      (res1)
    );

    rr_bypass_mux #(
        .BYP_LANES (BYP_LANES),
        .PHY_LOG   (PHY_LOG),
        .DATA_W    (DATA_W)
    ) u_byp2 (
        .tag_i       (a_src2_q),
        .prf_data_i  (prfData2_i),
        .byp_valid_i (bypValid_i),
        .byp_tag_i   (bypTag_i),
        .byp_data_i  (bypData_i),
        .data_o      (res2)
    );

    // Advance/capture decisions for both slots; flush kills both valids.
    always_comb begin
        adv_b     = !b_valid_q || exeReady_i;
        adv_a     = !a_valid_q || adv_b;

        a_valid_d = a_valid_q;
        a_src1_d  = a_src1_q;
        a_src2_d  = a_src2_q;
        a_pay_d   = a_pay_q;
        b_valid_d = b_valid_q;
        b_src1_d  = b_src1_q;
        b_src2_d  = b_src2_q;
        b_pay_d   = b_pay_q;

        if (adv_a) begin
            a_valid_d = issValid_i;
            a_src1_d  = issSrc1_i;
            a_src2_d  = issSrc2_i;
            a_pay_d   = issPayload_i;
        end
        if (adv_b) begin
            b_valid_d = a_valid_q;
            b_src1_d  = res1;
            b_src2_d  = res2;
            b_pay_d   = a_pay_q;
        end
        if (flush_i) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end
    end

    // Slot registers; zeroed on reset so every output is X-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid_q <= 1'b0;
            a_src1_q  <= '0;
            a_src2_q  <= '0;
            a_pay_q   <= '0;
            b_valid_q <= 1'b0;
            b_src1_q  <= '0;
            b_src2_q  <= '0;
            b_pay_q   <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            a_src1_q  <= a_src1_d;
            a_src2_q  <= a_src2_d;
            a_pay_q   <= a_pay_d;
            b_valid_q <= b_valid_d;
            b_src1_q  <= b_src1_d;
            b_src2_q  <= b_src2_d;
            b_pay_q   <= b_pay_d;
        end
    end

    assign rrReady_o    = adv_a && !flush_i;
    assign phySrc1_o    = a_src1_q;
    assign phySrc2_o    = a_src2_q;
    assign exeValid_o   = b_valid_q;
    assign exeSrc1_o    = b_src1_q;
    assign exeSrc2_o    = b_src2_q;
    assign exePayload_o = b_pay_q;

endmodule

// File: tb/tb_rr_operand_stage.sv
module tb_rr_operand_stage;

    localparam int L = 4;
    localparam int P = 7;
    localparam int D = 64;
    localparam int W = 96;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               issValid_i = 1'b0;
    logic [P-1:0]       issSrc1_i = '0, issSrc2_i = '0;
    logic [W-1:0]       issPayload_i = '0;
    logic               rrReady_o;
    logic [P-1:0]       phySrc1_o, phySrc2_o;
    logic [D-1:0]       prfData1_i, prfData2_i;
    logic [L-1:0]       bypValid_i = '0;
    logic [L*P-1:0]     bypTag_i = '0;
    logic [L*D-1:0]     bypData_i = '0;
    logic               exeValid_o;
    logic [D-1:0]       exeSrc1_o, exeSrc2_o;
    logic [W-1:0]       exePayload_o;
    logic               exeReady_i = 1'b1;
    logic               flush_i = 1'b0;

    always #5 clk = ~clk;

    rr_operand_stage dut (
        .clk          (clk),
        .reset        (reset),
        .issValid_i   (issValid_i),
        .issSrc1_i    (issSrc1_i),
        .issSrc2_i    (issSrc2_i),
        .issPayload_i (issPayload_i),
        .rrReady_o    (rrReady_o),
        .phySrc1_o    (phySrc1_o),
        .phySrc2_o    (phySrc2_o),
        .prfData1_i   (prfData1_i),
        .prfData2_i   (prfData2_i),
        .bypValid_i   (bypValid_i),
        .bypTag_i     (bypTag_i),
        .bypData_i    (bypData_i),
        .exeValid_o   (exeValid_o),
        .exeSrc1_o    (exeSrc1_o),
        .exeSrc2_o    (exeSrc2_o),
        .exePayload_o (exePayload_o),
        .exeReady_i   (exeReady_i),
        .flush_i      (flush_i)
    );

    // PRF model: combinational read, writes from writeback lanes land at the edge.
    logic [D-1:0] prf_mem [0:127];
    assign prfData1_i = prf_mem[phySrc1_o];
    assign prfData2_i = prf_mem[phySrc2_o];

    always @(posedge clk) begin
        for (int l = L - 1; l >= 0; l--)
            if (bypValid_i[l]) prf_mem[bypTag_i[l*P +: P]] <= bypData_i[l*D +: D];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: packets accepted by the stage must reach execute in order,
    // carrying the register values seen at issue; a flush discards everything
    // still in flight.
    typedef struct {
        logic [D-1:0] s1;
        logic [D-1:0] s2;
        logic [W-1:0] pay;
    } exp_t;
    exp_t sbq[$];
    bit   sb_en = 1'b0;
    int   delivered = 0;

    always @(posedge clk) begin
        exp_t e;
        if (sb_en && reset) begin
            if (exeValid_o && exeReady_i) begin
                delivered++;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected packet payload=%0h required=none", exePayload_o);
                end else begin
                    e = sbq.pop_front();
                    check("sb_src1", exeSrc1_o, e.s1);
                    check("sb_src2", exeSrc2_o, e.s2);
                    check("sb_payload", exePayload_o, e.pay);
                end
            end
            if (flush_i) sbq.delete();
            else if (issValid_i && rrReady_o)
                sbq.push_back('{prf_mem[issSrc1_i], prf_mem[issSrc2_i], issPayload_i});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [P-1:0] s1, input logic [P-1:0] s2, input logic [W-1:0] pay);
        issValid_i   = 1'b1;
        issSrc1_i    = s1;
        issSrc2_i    = s2;
        issPayload_i = pay;
    endtask

    function automatic logic [W-1:0] rnd_pay();
        return {$urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        logic [P-1:0]        s1, s2;
        logic [D-1:0]        p1, p2;
        logic [L-1:0]        bv;
        logic [L-1:0][P-1:0] bt;
        logic [L-1:0][D-1:0] bd;
        logic [D-1:0]        e1b, e2b, e1n, e2n;
    } vec_t;
    vec_t vt [7];

    initial begin
        logic [W-1:0] pay, payx, payy;
        logic [D-1:0] e1, e2;
        int cnt, run, maxrun;
        bit drained;

        vt[0] = '{7'd5, 7'd9, 64'h11, 64'h22, 4'b0000, '0, '0,
                  64'h11, 64'h22, 64'h11, 64'h22};
        vt[1] = '{7'd5, 7'd9, 64'h11, 64'h22, 4'b0100,
                  {7'd0, 7'd5, 7'd0, 7'd0}, {64'h0, 64'hAA, 64'h0, 64'h0},
                  64'hAA, 64'h22, 64'h11, 64'h22};
        vt[2] = '{7'd5, 7'd9, 64'h11, 64'h22, 4'b1010,
                  {7'd9, 7'd0, 7'd9, 7'd0}, {64'hB3, 64'h0, 64'hB1, 64'h0},
                  64'h11, 64'hB1, 64'h11, 64'h22};
        vt[3] = '{7'd5, 7'd9, 64'h11, 64'h22, 4'b0111,
                  {7'd0, 7'd5, 7'd9, 7'd5}, {64'h0, 64'hC2, 64'hD1, 64'hC0},
                  64'hC0, 64'hD1, 64'h11, 64'h22};
        vt[4] = '{7'd5, 7'd9, 64'h11, 64'h22, 4'b0000,
                  {7'd0, 7'd0, 7'd0, 7'd5}, {64'h0, 64'h0, 64'h0, 64'hEE},
                  64'h11, 64'h22, 64'h11, 64'h22};
        vt[5] = '{7'd12, 7'd12, 64'h33, 64'h33, 4'b1000,
                  {7'd12, 7'd0, 7'd0, 7'd0}, {64'h77, 64'h0, 64'h0, 64'h0},
                  64'h77, 64'h77, 64'h33, 64'h33};
        vt[6] = '{7'd0, 7'd127, 64'h1, 64'h2, 4'b0011,
                  {7'd0, 7'd0, 7'd127, 7'd0}, {64'h0, 64'h0, 64'hFF, 64'h5A},
                  64'h5A, 64'hFF, 64'h1, 64'h2};

        for (int i = 0; i < 128; i++) prf_mem[i] = {$urandom, $urandom};

        // Reset state
        #1;
        check("reset_exeValid", exeValid_o, 1'b0);
        #22 reset = 1'b1;
        tick();
        check("post_reset_rrReady", rrReady_o, 1'b1);
        check("post_reset_exeValid", exeValid_o, 1'b0);

        // Table-driven operand resolution: bypass driven while the packet sits in A
        for (int k = 0; k < 7; k++) begin
            prf_mem[vt[k].s1] = vt[k].p1;
            prf_mem[vt[k].s2] = vt[k].p2;
            pay = rnd_pay();
            issue(vt[k].s1, vt[k].s2, pay);
            tick();
            issValid_i = 1'b0;
            bypValid_i = vt[k].bv;
            bypTag_i   = vt[k].bt;
            bypData_i  = vt[k].bd;
            check("vec_latency_1cyc", exeValid_o, 1'b0);
            tick();
            bypValid_i = '0;
`ifdef RR_BYPASS_EN
            e1 = vt[k].e1b;
            e2 = vt[k].e2b;
`else
            e1 = vt[k].e1n;
            e2 = vt[k].e2n;
`endif
            check($sformatf("vec%0d_exeValid", k), exeValid_o, 1'b1);
            check($sformatf("vec%0d_src1", k), exeSrc1_o, e1);
            check($sformatf("vec%0d_src2", k), exeSrc2_o, e2);
            check($sformatf("vec%0d_payload", k), exePayload_o, pay);
            tick();
        end

        // PRF write landing while A is stalled must be observed
        prf_mem[30] = 64'h3030; prf_mem[31] = 64'h3131;
        prf_mem[20] = 64'h2020; prf_mem[21] = 64'h2121;
        exeReady_i = 1'b0;
        payx = rnd_pay();
        payy = rnd_pay();
        issue(7'd30, 7'd31, payx);
        tick();
        issue(7'd20, 7'd21, payy);
        tick();
        issValid_i  = 1'b0;
        prf_mem[20] = 64'h5555;
        tick();
        check("stall_x_valid", exeValid_o, 1'b1);
        check("stall_x_src1", exeSrc1_o, 64'h3030);
        exeReady_i = 1'b1;
        tick();
        check("stall_y_src1_reread", exeSrc1_o, 64'h5555);
        check("stall_y_src2", exeSrc2_o, 64'h2121);
        check("stall_y_payload", exePayload_o, payy);
        tick();
        check("stall_idle", exeValid_o, 1'b0);

        // Back-to-back: 8 issues give 8 consecutive exeValid cycles
        sb_en = 1'b1;
        cnt = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) issue(P'($urandom_range(0, 63)), P'($urandom_range(0, 63)), rnd_pay());
            else issValid_i = 1'b0;
            tick();
            if (exeValid_o) begin
                cnt++; run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
        end
        check("b2b_count", cnt, 8);
        check("b2b_run", maxrun, 8);

        // Stall for 3 cycles under a continuous issue stream
        for (int i = 0; i < 10; i++) begin
            issue(P'($urandom_range(0, 63)), P'($urandom_range(0, 63)), rnd_pay());
            exeReady_i = !(i >= 3 && i < 6);
            #1;
            if (i >= 3 && i < 6) begin
                check("stall_rrReady", rrReady_o, 1'b0);
                check("stall_exeValid", exeValid_o, 1'b1);
            end
            tick();
        end
        issValid_i = 1'b0;
        exeReady_i = 1'b1;
        repeat (4) tick();
        check("stall_drain_empty", sbq.size(), 0);

        // Flush with both slots valid and an issue in the same cycle
        for (int i = 0; i < 3; i++) begin
            issue(P'($urandom_range(0, 63)), P'($urandom_range(0, 63)), rnd_pay());
            tick();
        end
        issue(7'd1, 7'd2, rnd_pay());
        flush_i = 1'b1;
        #1;
        check("flush_rrReady", rrReady_o, 1'b0);
        tick();
        flush_i    = 1'b0;
        issValid_i = 1'b0;
        check("flush_exeValid", exeValid_o, 1'b0);
        tick();
        check("flush_quiet", exeValid_o, 1'b0);
        issue(7'd3, 7'd4, rnd_pay());
        tick();
        issValid_i = 1'b0;
        check("post_flush_lat1", exeValid_o, 1'b0);
        tick();
        check("post_flush_lat2", exeValid_o, 1'b1);
        tick();

        // Asynchronous reset mid-operation
        issue(7'd10, 7'd11, rnd_pay());
        tick();
        issue(7'd12, 7'd13, rnd_pay());
        tick();
        issValid_i = 1'b0;
        check("rst_pre_exeValid", exeValid_o, 1'b1);
        #2 reset = 1'b0;
        sbq.delete();
        #1;
        check("rst_async_exeValid", exeValid_o, 1'b0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_rel_rrReady", rrReady_o, 1'b1);
        check("rst_rel_exeValid", exeValid_o, 1'b0);
        issue(7'd14, 7'd15, rnd_pay());
        tick();
        issValid_i = 1'b0;
        check("rst_first_lat1", exeValid_o, 1'b0);
        tick();
        check("rst_first_lat2", exeValid_o, 1'b1);
        tick();

        // Randomized traffic; bypass writes target tags that are never read
        for (int c = 0; c < 400; c++) begin
            issValid_i   = ($urandom_range(0, 3) != 0);
            issSrc1_i    = P'($urandom_range(0, 63));
            issSrc2_i    = P'($urandom_range(0, 63));
            issPayload_i = rnd_pay();
            exeReady_i   = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 39) == 0);
            bypValid_i   = L'($urandom);
            for (int l = 0; l < L; l++) begin
                bypTag_i[l*P +: P]  = P'($urandom_range(64, 127));
                bypData_i[l*D +: D] = {$urandom, $urandom};
            end
            tick();
        end
        issValid_i = 1'b0;
        flush_i    = 1'b0;
        bypValid_i = '0;
        exeReady_i = 1'b1;
        drained = 1'b0;
        for (int c = 0; c < 10 && !drained; c++) begin
            tick();
            if (sbq.size() == 0 && !exeValid_o) drained = 1'b1;
        end
        check("rand_drain_done", drained, 1'b1);
        check("rand_drain_empty", sbq.size(), 0);
        check("rand_some_delivered", (delivered > 50), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
